// File: rtl/cpu_loader_pkg.sv
// cpu_loader_pkg: header op codes and FSM state encoding shared by the
// loader top and its run counter.
//
// Build option:
//   CPU_LOADER_DUMP_EN - when defined, the data-memory dump states exist and
//                        op 11 reads data memory back out on the m_* stream.
//                        When undefined, op 11 is rejected with an err pulse.

package cpu_loader_pkg;

    // Header op field, bits [31:30] of a header word.
    typedef enum logic [1:0] {
        OP_LD_I = 2'b00,  // load instruction memory, one 32-bit word per beat
        OP_LD_D = 2'b01,  // load data memory, two beats (lo, hi) per 64-bit word
        OP_RUN  = 2'b10,  // enable the CPU for `count` cycles
        OP_DUMP = 2'b11   // read data memory back, two beats per 64-bit word
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LD_I    = 4'd1,
        ST_LD_D_LO = 4'd2,
        ST_LD_D_HI = 4'd3,
        ST_RUN     = 4'd4
`ifdef CPU_LOADER_DUMP_EN
        ,
        ST_RD_REQ  = 4'd5,
        ST_RD_WAIT = 4'd6,
        ST_TX_LO   = 4'd7,
        ST_TX_HI   = 4'd8
`endif
    } state_e;

`ifdef CPU_LOADER_DUMP_EN
    localparam bit DUMP_EN = 1'b1;
`else
    localparam bit DUMP_EN = 1'b0;
`endif

    // Bit position of the header base field.
    localparam int BASE_LSB = 16;

endpackage

// File: rtl/cpu_loader_runctr.sv
// cpu_loader_runctr: down-counter timing the RUN phase.
//
// Ports:
//   clk, arst  - clock, asynchronous active-high reset
//   load       - load `load_val` (takes priority over dec)
//   load_val   - value to load; the caller loads count-1 so that `zero`
//                marks the last RUN cycle
//   dec        - decrement by one (saturates at zero)
//   zero       - counter currently equals zero

module cpu_loader_runctr #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cpu_loader.sv
// cpu_loader: host-driven loader for a small CPU. A header word on the
// s_* stream selects one of: load instruction memory, load data memory,
// run the CPU for N cycles, or dump data memory on the m_* stream.
//
// Handshake: a word moves on either stream only in a cycle where its valid
// and ready are both high; valid/data are held by the sender until ready.
//
// Header word: op=[31:30], base=[BASE_W+15:16], count=[CNT_W-1:0].
//
// Ports:
//   clk, arst               - clock, asynchronous active-high reset
//   s_valid/s_ready/s_data  - host -> loader words (header or payload)
//   m_valid/m_ready/m_data  - loader -> host dump words
//   cpu_enable              - CPU enable, high only during RUN
//   addr_ext/wen_ext/ren_ext/wdata_ext          - instruction memory port
//   addr_ext_2/wen_ext_2/ren_ext_2/wdata_ext_2/rdata_ext_2 - data memory port
//   busy                    - not IDLE
//   done                    - one-cycle pulse on return to IDLE after a command
//   err                     - one-cycle pulse on an illegal header
//
// Build option:
//   CPU_LOADER_DUMP_EN - enables the dump command (op 11). Without it the
//                        m_* stream and ren_ext_2 are tied low and op 11
//                        pulses err.

module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int BASE_W = 14
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        cpu_enable,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    input  logic [63:0] rdata_ext_2,
    output logic        busy,
    output logic        done,
    output logic        err
);

    state_e            state_q, state_d;
    logic [BASE_W-1:0] base_q;
    logic [CNT_W-1:0]  last_q;   // index of the final word of the command
    logic [CNT_W-1:0]  idx_q;
    logic [31:0]       lo_q;
    logic              done_q, err_q, cpu_en_q;

    op_e               hdr_op;
    logic [BASE_W-1:0] hdr_base;
    logic [CNT_W-1:0]  hdr_count;

    logic              rdy_state, s_fire, is_last;
    logic [63:0]       word_idx;
    logic              hdr_take, idx_inc, done_set, err_set;
    logic              run_load, run_dec, run_zero;

    assign hdr_op    = op_e'(s_data[31:30]);
    assign hdr_base  = s_data[BASE_W+BASE_LSB-1:BASE_LSB];
    assign hdr_count = s_data[CNT_W-1:0];

    // Word index widened before the add so base+i never wraps.
    assign word_idx = 64'(base_q) + 64'(idx_q);
    assign is_last  = (idx_q == last_q);

    assign rdy_state = (state_q == ST_IDLE) || (state_q == ST_LD_I) ||
                       (state_q == ST_LD_D_LO) || (state_q == ST_LD_D_HI);
    // Reset forces ready low combinationally so no output is high during arst.
    assign s_ready = rdy_state && !arst;
    assign s_fire  = s_valid && s_ready;

`ifdef CPU_LOADER_DUMP_EN
    logic [63:0] cap_q;
    logic        m_fire;
    assign m_fire = m_valid && m_ready;
`endif

    cpu_loader_runctr #(
        .W(CNT_W)
    ) u_runctr (
        .clk      (clk),
        .arst     (arst),
        .load     (run_load),
        .load_val (hdr_count - CNT_W'(1)),
        .dec      (run_dec),
        .zero     (run_zero)
    );

    // State register.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d  = state_q;
        hdr_take = 1'b0;
        idx_inc  = 1'b0;
        done_set = 1'b0;
        err_set  = 1'b0;
        run_load = 1'b0;
        run_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    hdr_take = 1'b1;
                    if ((hdr_op == OP_DUMP) && !DUMP_EN) begin
                        err_set = 1'b1;
                    end else if (hdr_count == '0) begin
                        done_set = 1'b1;
                    end else begin
                        case (hdr_op)
                            OP_LD_I: state_d = ST_LD_I;
                            OP_LD_D: state_d = ST_LD_D_LO;
                            OP_RUN: begin
                                state_d  = ST_RUN;
                                run_load = 1'b1;
                            end
                            default: begin
`ifdef CPU_LOADER_DUMP_EN
                                state_d = ST_RD_REQ;
`endif
                            end
                        endcase
                    end
                end
            end
            ST_LD_I: begin
                if (s_fire) begin
                    idx_inc = 1'b1;
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end
                end
            end
            ST_LD_D_LO: begin
                if (s_fire) begin
                    state_d = ST_LD_D_HI;
                end
            end
            ST_LD_D_HI: begin
                if (s_fire) begin
                    idx_inc = 1'b1;
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = ST_LD_D_LO;
                    end
                end
            end
            ST_RUN: begin
                // Counter holds count-1 on entry, so RUN lasts `count` cycles.
                if (run_zero) begin
                    state_d  = ST_IDLE;
                    done_set = 1'b1;
                end else begin
                    run_dec = 1'b1;
                end
            end
`ifdef CPU_LOADER_DUMP_EN
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = ST_TX_LO;
            ST_TX_LO: begin
                if (m_fire) begin
                    state_d = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                if (m_fire) begin
                    idx_inc = 1'b1;
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Command registers and registered pulses.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            base_q   <= '0;
            last_q   <= '0;
            idx_q    <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cpu_en_q <= 1'b0;
        end else begin
            done_q   <= done_set;
            err_q    <= err_set;
            // Registered enable that is high exactly while the state is RUN.
            cpu_en_q <= (state_d == ST_RUN);
            if (hdr_take) begin
                base_q <= hdr_base;
                last_q <= hdr_count - CNT_W'(1);
                idx_q  <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + CNT_W'(1);
            end
            if ((state_q == ST_LD_D_LO) && s_fire) begin
                lo_q <= s_data;
            end
        end
    end

`ifdef CPU_LOADER_DUMP_EN
    // Read latency is one cycle: data requested in RD_REQ is on rdata_ext_2
    // during RD_WAIT.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cap_q <= '0;
        end else if (state_q == ST_RD_WAIT) begin
            cap_q <= rdata_ext_2;
        end
    end
`else
    logic unused_dump;
    assign unused_dump = ^{m_ready, rdata_ext_2};
`endif

    // Memory and dump-stream outputs, zero outside the states that own them.
    always_comb begin
        addr_ext    = '0;
        wen_ext     = 1'b0;
        wdata_ext   = '0;
        addr_ext_2  = '0;
        wen_ext_2   = 1'b0;
        ren_ext_2   = 1'b0;
        wdata_ext_2 = '0;
        m_valid     = 1'b0;
        m_data      = '0;
        case (state_q)
            ST_LD_I: begin
                addr_ext  = {word_idx[61:0], 2'b00};
                wdata_ext = s_data;
                wen_ext   = s_fire;
            end
            ST_LD_D_HI: begin
                addr_ext_2  = {word_idx[60:0], 3'b000};
                wdata_ext_2 = {s_data, lo_q};
                wen_ext_2   = s_fire;
            end
`ifdef CPU_LOADER_DUMP_EN
            ST_RD_REQ: begin
                addr_ext_2 = {word_idx[60:0], 3'b000};
                ren_ext_2  = 1'b1;
            end
            ST_TX_LO: begin
                m_valid = 1'b1;
                m_data  = cap_q[31:0];
            end
            ST_TX_HI: begin
                m_valid = 1'b1;
                m_data  = cap_q[63:32];
            end
`endif
            default: ;
        endcase
    end

    assign ren_ext    = 1'b0;
    assign cpu_enable = cpu_en_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_cpu_loader.sv
// tb_cpu_loader: directed bench for cpu_loader. Expected memory writes,
// read requests and dump beats are derived from the header fields with
// plain arithmetic and queued; a negedge compare process pops and checks
// them whenever the DUT shows the matching strobe.

module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        cpu_enable;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic [63:0] rdata_ext_2 = '0;
    logic        busy;
    logic        done;
    logic        err;

    cpu_loader dut (
        .clk         (clk),
        .arst        (arst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .cpu_enable  (cpu_enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext_2 (rdata_ext_2),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    int run_cycles = 0;
    logic tog_en = 1'b0;

    logic [95:0]  exp_iw_q[$];   // {addr, data} instruction memory writes
    logic [127:0] exp_dw_q[$];   // {addr, data} data memory writes
    logic [63:0]  exp_ra_q[$];   // data memory read addresses
    logic [31:0]  exp_beat_q[$]; // dump beats

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic fail_ev(input string name, input logic [127:0] got);
        total++;
        bad++;
        $display("FAIL %s: got %0h required no event", name, got);
    endtask

    // Data memory contents as seen by the bench.
    function automatic logic [63:0] dmem_rd(input logic [63:0] a);
        if (a == 64'd24) return 64'h01234567_DEADBEEF;
        return {a[31:0] ^ 32'h5555_0000, a[31:0] + 32'h0000_1000};
    endfunction

    // One-cycle-latency data memory.
    logic        rd_pend = 1'b0;
    logic [63:0] rd_addr = '0;
    always @(negedge clk) begin
        if (!arst && ren_ext_2) begin
            rd_pend = 1'b1;
            rd_addr = addr_ext_2;
        end
    end
    always @(posedge clk) begin
        if (rd_pend) begin
            #1;
            rdata_ext_2 = dmem_rd(rd_addr);
            rd_pend = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            m_ready = ~m_ready;
        end
    end

    // Compare process.
    logic        hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    always @(negedge clk) begin
        if (!arst) begin
            chk("ren_ext_tied", ren_ext, 1'b0);
            if (wen_ext) begin
                if (exp_iw_q.size() == 0) fail_ev("imem_write_unexpected", {addr_ext, wdata_ext});
                else chk("imem_write", {addr_ext, wdata_ext}, exp_iw_q.pop_front());
            end
            if (wen_ext_2) begin
                if (exp_dw_q.size() == 0) fail_ev("dmem_write_unexpected", {addr_ext_2, wdata_ext_2});
                else chk("dmem_write", {addr_ext_2, wdata_ext_2}, exp_dw_q.pop_front());
            end
            if (ren_ext_2) begin
                if (exp_ra_q.size() == 0) fail_ev("dmem_read_unexpected", addr_ext_2);
                else chk("dmem_read_addr", addr_ext_2, exp_ra_q.pop_front());
            end
            if (m_valid) begin
                if (hold_pend) chk("m_data_held", m_data, hold_data);
                if (m_ready) begin
                    if (exp_beat_q.size() == 0) fail_ev("dump_beat_unexpected", m_data);
                    else chk("dump_beat", m_data, exp_beat_q.pop_front());
                    hold_pend = 1'b0;
                end else begin
                    hold_pend = 1'b1;
                    hold_data = m_data;
                end
            end else if (hold_pend) begin
                fail_ev("m_valid_dropped", hold_data);
                hold_pend = 1'b0;
            end
            if (cpu_enable) begin
                run_cycles++;
                chk("run_sready_low", s_ready, 1'b0);
                chk("run_no_mem_access", {wen_ext, wen_ext_2, ren_ext_2}, 3'b000);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = w;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) fail_ev("s_ready_timeout", w);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = '0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < bound) begin
            n++;
            @(negedge clk);
        end
        chk(name, done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, |{s_ready, m_valid, m_data, cpu_enable, addr_ext, wen_ext, ren_ext,
                    wdata_ext, addr_ext_2, wen_ext_2, ren_ext_2, wdata_ext_2,
                    busy, done, err}, 1'b0);
    endtask

    // Model-driven commands: expectations follow from base/count alone.
    task automatic ld_i_cmd(input int base, input int n);
        logic [31:0] w[$];
        for (int k = 0; k < n; k++) begin
            w.push_back(32'hC0DE_0000 ^ (k * 32'h0101) ^ base);
            exp_iw_q.push_back({64'(base + k) * 64'd4, w[k]});
        end
        send_word({2'b00, 14'(base), 16'(n)});
        for (int k = 0; k < n; k++) begin
            idle(k % 2);
            send_word(w[k]);
        end
        wait_done("ld_i_done", 4);
    endtask

    task automatic ld_d_cmd(input int base, input int n);
        logic [63:0] w[$];
        for (int k = 0; k < n; k++) begin
            w.push_back({32'hA000_0000 + k, 32'h0B00_0000 ^ base ^ (k << 4)});
            exp_dw_q.push_back({64'(base + k) * 64'd8, w[k]});
        end
        send_word({2'b01, 14'(base), 16'(n)});
        for (int k = 0; k < n; k++) begin
            send_word(w[k][31:0]);
            idle(k % 2);
            send_word(w[k][63:32]);
        end
        wait_done("ld_d_done", 4);
    endtask

    task automatic run_cmd(input int n);
        run_cycles = 0;
        send_word({2'b10, 14'd0, 16'(n)});
        wait_done("run_done", n + 5);
        chk("run_length", run_cycles, n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset with a word offered: nothing may be accepted or driven.
        s_valid = 1'b1;
        s_data  = 32'h0000_0001;
        #1;
        check_all_zero("reset_outputs_t0");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("reset_outputs_held");
        s_valid = 1'b0;
        s_data  = '0;
        arst = 1'b0;
        #1;
        chk("idle_after_reset", {busy, s_ready, cpu_enable}, 3'b010);
        idle(1);

        // Two instruction words at byte addresses 0 and 4.
        exp_iw_q.push_back({64'd0, 32'h00500093});
        exp_iw_q.push_back({64'd4, 32'h00108133});
        send_word(32'h0000_0002);
        chk("ld_i_busy", busy, 1'b1);
        send_word(32'h00500093);
        send_word(32'h00108133);
        wait_done("lit_ld_i_done", 3);

        // One data word, base 3 -> byte address 24.
        exp_dw_q.push_back({64'd24, 64'h01234567_DEADBEEF});
        send_word(32'h4003_0001);
        send_word(32'hDEADBEEF);
        send_word(32'h01234567);
        wait_done("lit_ld_d_done", 3);

        // Run for 10 cycles, then boundary of 1.
        run_cycles = 0;
        send_word(32'h8000_000A);
        wait_done("lit_run_done", 20);
        chk("lit_run_10", run_cycles, 10);
        run_cmd(1);
        run_cmd(3);

        // Count 0: done on the very next cycle, nothing written.
        send_word(32'h0000_0000);
        chk("cnt0_done_next", {done, busy}, 2'b10);
        idle(1);
        chk("cnt0_done_pulse", done, 1'b0);
        send_word(32'h4005_0000);
        chk("cnt0_ld_d_done", done, 1'b1);
        idle(1);

        // Top of the base range: base+i must carry past BASE_W bits.
        exp_iw_q.push_back({64'h0000_FFFC, 32'h1111_0000});
        exp_iw_q.push_back({64'h0001_0000, 32'h1111_0001});
        exp_iw_q.push_back({64'h0001_0004, 32'h1111_0002});
        send_word(32'h3FFF_0003);
        send_word(32'h1111_0000);
        send_word(32'h1111_0001);
        send_word(32'h1111_0002);
        wait_done("lit_wrap_done", 3);

        ld_i_cmd(5, 4);
        ld_d_cmd(16'h3FFE, 3);
        ld_d_cmd(7, 1);

`ifdef CPU_LOADER_DUMP_EN
        // Dump base 3, count 1, with m_ready toggling.
        exp_ra_q.push_back(64'd24);
        exp_beat_q.push_back(32'hDEADBEEF);
        exp_beat_q.push_back(32'h01234567);
        m_ready = 1'b0;
        tog_en  = 1'b1;
        send_word(32'hC003_0001);
        wait_done("lit_dump_done", 30);
        // Two more words from base 0x10, derived from the memory model.
        for (int k = 0; k < 2; k++) begin
            exp_ra_q.push_back(64'(16 + k) * 64'd8);
            exp_beat_q.push_back(dmem_rd(64'(16 + k) * 64'd8) & 64'hFFFF_FFFF);
            exp_beat_q.push_back(dmem_rd(64'(16 + k) * 64'd8) >> 32);
        end
        send_word(32'hC010_0002);
        wait_done("dump2_done", 40);
        tog_en  = 1'b0;
        #2;
        m_ready = 1'b0;
        idle(1);
`else
        // Dump not built: header consumed, err pulse, stays IDLE.
        send_word(32'hC003_0001);
        chk("dump_err_pulse", {err, done, busy, m_valid}, 4'b1000);
        idle(1);
        chk("dump_err_cleared", {err, busy}, 2'b00);
`endif

        // Reset in the middle of LD_D_HI with the high word offered.
        send_word(32'h4001_0002);
        send_word(32'h1111_1111);
        s_valid = 1'b1;
        s_data  = 32'h2222_2222;
        #2;
        arst = 1'b1;
        #1;
        check_all_zero("rst_mid_ld_d");
        s_valid = 1'b0;
        s_data  = '0;
        @(posedge clk);
        #1;
        arst = 1'b0;
        idle(1);

        // Reset in the middle of RUN.
        send_word(32'h8000_000A);
        idle(3);
        chk("run_active_before_rst", cpu_enable, 1'b1);
        #2;
        arst = 1'b1;
        #1;
        check_all_zero("rst_mid_run");
        @(posedge clk);
        #1;
        arst = 1'b0;
        idle(1);

        send_word(32'h0000_0000);
        chk("post_rst_done", done, 1'b1);
        idle(1);
        chk("post_rst_idle", {done, busy}, 2'b00);

        idle(2);
        chk("imem_q_empty", exp_iw_q.size(), 0);
        chk("dmem_q_empty", exp_dw_q.size(), 0);
        chk("read_q_empty", exp_ra_q.size(), 0);
        chk("beat_q_empty", exp_beat_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cpu_loader.md
CPU_LOADER -- requirements
Module: cpu_loader

Interface
REQ-001 The block SHALL have one clock, `clk`, and one reset, `arst`; reset is asynchronous and active-high.
REQ-002 Parameter `CNT_W`, default 16, SHALL set the width of the header count field.
REQ-003 Parameter `BASE_W`, default 14, SHALL set the width of the header base-word-index field.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock
- arst  in  1  async active-high reset
- s_valid  in  1  host word valid
- s_ready  out  1  loader accepts word
- s_data  in  32  host word (header or payload)
- m_valid  out  1  dump word valid
- m_ready  in  1  host accepts dump word
- m_data  out  32  dump word
- cpu_enable  out  1  drives the CPU enable input
- addr_ext  out  64  instruction memory external byte address
- wen_ext  out  1  instruction memory external write enable
- ren_ext  out  1  instruction memory external read enable; tied 0
- wdata_ext  out  32  instruction memory external write word
- addr_ext_2  out  64  data memory external byte address
- wen_ext_2  out  1  data memory external write enable
- ren_ext_2  out  1  data memory external read enable
- wdata_ext_2  out  64  data memory external write word
- rdata_ext_2  in  64  data memory read word
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on return to IDLE after a command
- err  out  1  one-cycle pulse on an illegal header

Function
REQ-005 A transfer on either stream SHALL occur only on a cycle where valid and ready are both high; `s_ready` SHALL be high only in IDLE, LD_I, LD_D_LO and LD_D_HI.
REQ-006 Header word layout SHALL be: op=[31:30], base=[BASE_W+15:16], count=[CNT_W-1:0].
- op 00 = load instruction memory
- op 01 = load data memory
- op 10 = run
- op 11 = dump data memory
REQ-007 States SHALL be IDLE, LD_I, LD_D_LO, LD_D_HI, RUN, RD_REQ, RD_WAIT, TX_LO, TX_HI. A header is accepted in IDLE; a count of 0 SHALL return the block to IDLE on the next cycle with `done` pulsed.
REQ-008 LD_I: each accepted word SHALL drive `wen_ext`=1, `wdata_ext`=word and `addr_ext`=4*(base+i) in the same cycle; after `count` words the block SHALL go to IDLE.
REQ-009 LD_D_LO: each accepted word SHALL be latched as the low half of a 64-bit word. LD_D_HI: each accepted word SHALL drive `wen_ext_2`=1, `wdata_ext_2`={word, low} and `addr_ext_2`=8*(base+i).
REQ-010 RUN: `cpu_enable` SHALL be high for exactly `count` consecutive cycles, registered; the block SHALL then go to IDLE.
REQ-011 RD_REQ SHALL drive `ren_ext_2`=1 and `addr_ext_2`=8*(base+i) for one cycle. RD_WAIT SHALL capture `rdata_ext_2` one cycle later; data memory read latency is fixed at 1.
REQ-012 TX_LO SHALL present the captured [31:0]; TX_HI SHALL present [63:32]. `m_valid` and `m_data` SHALL hold stable until `m_ready`. After `count` words the block SHALL go to IDLE.
REQ-013 Word index `i` SHALL be a CNT_W-bit counter; address arithmetic SHALL be 64-bit, and base+i SHALL NOT wrap within BASE_W bits.
REQ-014 Write enables and read enable SHALL be high only on the cycles named above. `cpu_enable` SHALL be 0 in every state except RUN, so memory access never overlaps CPU execution.
REQ-015 `done` SHALL pulse on the cycle the state returns to IDLE after any legal command.

Reset
REQ-016 On `arst`, including mid-command, the state SHALL go to IDLE and every output SHALL go to 0 immediately; any partial transfer is discarded.

Configuration
REQ-017 With `CPU_LOADER_DUMP_EN` defined, op 11 SHALL behave per REQ-011/012.
REQ-018 Without `CPU_LOADER_DUMP_EN`:
- RD_REQ, RD_WAIT, TX_LO and TX_HI SHALL be absent.
- `m_valid` and `ren_ext_2` SHALL be tied 0.
- An op 11 header SHALL be consumed, pulse `err`, and leave the block in IDLE.

Structure
REQ-019 Op encodings and state encodings SHALL live in shared package `cpu_loader_pkg`.
REQ-020 The RUN cycle counter SHALL be sub-module `cpu_loader_runctr` (load, decrement, zero flag); everything else SHALL be flat.

Verification
REQ-021 Header 0x0000_0002, then words 0x00500093, 0x00108133 -> `wen_ext` pulses at `addr_ext` 0 and 4 with those words, then `done`.
REQ-022 Header 0x4003_0001, then words 0xDEADBEEF, 0x01234567 -> a single `wen_ext_2` at `addr_ext_2` 24 with 0x01234567DEADBEEF.
REQ-023 Header 0x8000_000A -> `cpu_enable` high for exactly 10 cycles, `s_ready` low throughout, then `done`.
REQ-024 Dump with `CPU_LOADER_DUMP_EN`: header 0xC003_0001 with `rdata_ext_2`=0x01234567DEADBEEF and `m_ready` toggling every other cycle -> beats 0xDEADBEEF then 0x01234567, each held until accepted. Without the macro -> `err` pulses and the block stays in IDLE.
REQ-025 Assert `arst` mid-LD_D_HI and mid-RUN -> all outputs 0 at once, no write issued; the next header 0x0000_0000 yields `done` one cycle later.
